// File: rtl/pyrm_writeback_block_pkg.sv
// pyrm_writeback_block_pkg
//   Shared definitions for the pyrm writeback stage: RV64 opcode and load
//   funct3 encodings, the writeback FSM state type, the write-queue entry
//   type and the "does this opcode write rd" decode helper.
package pyrm_writeback_block_pkg;

  // RV64 major opcodes (inst[6:0])
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_64ARITH   = 7'b0111011;
  localparam logic [6:0] OP_ARITH_I   = 7'b0010011;
  localparam logic [6:0] OP_64ARITH_I = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] SCALL        = 7'b1110011;

  // Load funct3 encodings (inst[14:12] of OP_LOAD)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_LOAD
  } wb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  // Opcodes whose result is written to rd; everything else retires silently.
  function automatic logic op_writes_rd(input logic [6:0] op);
    case (op)
      OP_ARITH, OP_64ARITH, OP_ARITH_I, OP_64ARITH_I,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pyrm_wb_fifo.sv
// pyrm_wb_fifo
//   Synchronous FIFO of wb_entry_t, DEPTH entries (power of two, >= 2).
//   Ports:
//     clk, reset_pyri   clock / asynchronous active-low reset
//     push, din         write request and entry (ignored when full)
//     pop               read request (ignored when empty)
//     dout              head entry, all zeros when empty
//     count, full, empty occupancy status (registered)
module pyrm_wb_fifo
  import pyrm_writeback_block_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_pyri,
  input  logic                         push,
  input  wb_entry_t                    din,
  input  logic                         pop,
  output wb_entry_t                    dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // Push looks only at the registered full flag, so a pop in the same
  // cycle never makes room for a push into a full queue.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pyrm_writeback_block.sv
// pyrm_writeback_block
//   Writeback stage of the pyrm RV64 pipeline. Accepts executed instructions
//   with their result, waits for load data on loads, formats the loaded
//   value and queues register writes in order towards decode.
//   Ports:
//     clk, reset_pyri                     clock / async active-low reset
//     inst_pyri, inst_valid/retry         executed instruction channel
//     result_pyri, result_valid/retry     ALU result or load address channel
//     load_data_pyri, load_data_valid/retry  aligned doubleword from dmem
//     reg_addr_pyro, reg_addr_valid/retry register-write address (rd in [4:0])
//     reg_data_pyro, reg_data_valid/retry register-write data
module pyrm_writeback_block
  import pyrm_writeback_block_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_pyri,
  input  logic [31:0] inst_pyri,
  input  logic        inst_valid_pyri,
  output logic        inst_retry_pyro,
  input  logic [63:0] result_pyri,
  input  logic        result_valid_pyri,
  output logic        result_retry_pyro,
  input  logic [63:0] load_data_pyri,
  input  logic        load_data_valid_pyri,
  output logic        load_data_retry_pyro,
  output logic [63:0] reg_addr_pyro,
  output logic        reg_addr_valid_pyro,
  input  logic        reg_addr_retry_pyri,
  output logic [63:0] reg_data_pyro,
  output logic        reg_data_valid_pyro,
  input  logic        reg_data_retry_pyri
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  wb_state_t     state_q;
  wb_state_t     state_d;
  logic [4:0]    ld_rd_q;
  logic [2:0]    ld_f3_q;
  logic [2:0]    ld_off_q;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  wb_entry_t     head;
  wb_entry_t     push_entry;
  logic          push;
  logic          pop;

  logic          stall;
  logic          inst_accept;
  logic          ld_accept;
  logic [6:0]    op;
  logic [4:0]    rd;
  logic [2:0]    f3;
  logic          unused_bits;

  assign op = inst_pyri[6:0];
  assign rd = inst_pyri[11:7];
  assign f3 = inst_pyri[14:12];
  assign unused_bits = ^{inst_pyri[31:15], full};

  // Byte/half/word select from the aligned doubleword, then extend.
  function automatic logic [63:0] load_extract(input logic [63:0] d,
                                               input logic [2:0]  fn3,
                                               input logic [2:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = d[{off[2], 5'b00000} +: 32];
    case (fn3)
      F3_LB:   return {{56{b[7]}}, b};
      F3_LH:   return {{48{h[15]}}, h};
      F3_LW:   return {{32{w[31]}}, w};
      F3_LBU:  return {56'b0, b};
      F3_LHU:  return {48'b0, h};
      F3_LWU:  return {32'b0, w};
      default: return d;
    endcase
  endfunction

  // Handshake retries depend on registered state only.
  assign stall                = (count == CW'(FIFO_DEPTH)) || (state_q == ST_WAIT_LOAD);
  assign inst_retry_pyro      = stall;
  assign result_retry_pyro    = stall;
  assign load_data_retry_pyro = !((state_q == ST_WAIT_LOAD) && (count < CW'(FIFO_DEPTH)));

  assign inst_accept = inst_valid_pyri && result_valid_pyri && !stall;
  assign ld_accept   = load_data_valid_pyri && !load_data_retry_pyro;

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      state_q  <= ST_IDLE;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
    end else begin
      state_q <= state_d;
      if (inst_accept && (op == OP_LOAD)) begin
        ld_rd_q  <= rd;
        ld_f3_q  <= f3;
        ld_off_q <= result_pyri[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      ST_IDLE: begin
        if (inst_accept) begin
          if (op == OP_LOAD) begin
            // Loads to x0 still wait for their data so memory stays in step.
            state_d = ST_WAIT_LOAD;
          end else if (op_writes_rd(op) && (rd != 5'd0)) begin
            push            = 1'b1;
            push_entry.rd   = rd;
            push_entry.data = result_pyri;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (ld_accept) begin
          state_d = ST_IDLE;
          if (ld_rd_q != 5'd0) begin
            push            = 1'b1;
            push_entry.rd   = ld_rd_q;
            push_entry.data = load_extract(load_data_pyri, ld_f3_q, ld_off_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign reg_addr_valid_pyro = !empty;
  assign reg_data_valid_pyro = !empty;
  assign reg_addr_pyro       = {59'b0, head.rd};
  assign reg_data_pyro       = head.data;
  assign pop = reg_addr_valid_pyro && reg_data_valid_pyro &&
               !reg_addr_retry_pyri && !reg_data_retry_pyri;

  pyrm_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_pyri (reset_pyri),
    .push       (push),
    .din        (push_entry),
    .pop        (pop),
    .dout       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_pyrm_writeback_block.sv
// tb_pyrm_writeback_block
//   Scoreboard bench for pyrm_writeback_block: expected register writes are
//   queued as instructions are issued; a monitor pops and compares on every
//   output transfer. Directed cases plus randomized traffic with random
//   output backpressure.
module tb_pyrm_writeback_block;

  localparam int unsigned DEPTH = 2;

  localparam logic [6:0] T_ARITH   = 7'h33;
  localparam logic [6:0] T_ARITH64 = 7'h3B;
  localparam logic [6:0] T_ARITHI  = 7'h13;
  localparam logic [6:0] T_ARITHI64= 7'h1B;
  localparam logic [6:0] T_LUI     = 7'h37;
  localparam logic [6:0] T_AUIPC   = 7'h17;
  localparam logic [6:0] T_JAL     = 7'h6F;
  localparam logic [6:0] T_JALR    = 7'h67;
  localparam logic [6:0] T_LOAD    = 7'h03;
  localparam logic [6:0] T_STORE   = 7'h23;
  localparam logic [6:0] T_BRANCH  = 7'h63;
  localparam logic [6:0] T_SCALL   = 7'h73;
  localparam logic [6:0] T_UNKNOWN = 7'h7F;

  logic        clk = 1'b0;
  logic        reset_pyri;
  logic [31:0] inst_pyri;
  logic        inst_valid_pyri;
  logic        inst_retry_pyro;
  logic [63:0] result_pyri;
  logic        result_valid_pyri;
  logic        result_retry_pyro;
  logic [63:0] load_data_pyri;
  logic        load_data_valid_pyri;
  logic        load_data_retry_pyro;
  logic [63:0] reg_addr_pyro;
  logic        reg_addr_valid_pyro;
  logic        reg_addr_retry_pyri;
  logic [63:0] reg_data_pyro;
  logic        reg_data_valid_pyro;
  logic        reg_data_retry_pyri;

  int checks = 0;
  int errors = 0;
  bit rand_bp = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pyrm_writeback_block #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                  (clk),
    .reset_pyri           (reset_pyri),
    .inst_pyri            (inst_pyri),
    .inst_valid_pyri      (inst_valid_pyri),
    .inst_retry_pyro      (inst_retry_pyro),
    .result_pyri          (result_pyri),
    .result_valid_pyri    (result_valid_pyri),
    .result_retry_pyro    (result_retry_pyro),
    .load_data_pyri       (load_data_pyri),
    .load_data_valid_pyri (load_data_valid_pyri),
    .load_data_retry_pyro (load_data_retry_pyro),
    .reg_addr_pyro        (reg_addr_pyro),
    .reg_addr_valid_pyro  (reg_addr_valid_pyro),
    .reg_addr_retry_pyri  (reg_addr_retry_pyri),
    .reg_data_pyro        (reg_data_pyro),
    .reg_data_valid_pyro  (reg_data_valid_pyro),
    .reg_data_retry_pyri  (reg_data_retry_pyri)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {T_ARITH, T_ARITH64, T_ARITHI, T_ARITHI64, T_LUI,
                      T_AUIPC, T_JAL, T_JALR, T_LOAD};
  endfunction

  // Reference load formatting: shift the aligned field down, mask to its
  // size, extend by the top bit unless unsigned.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] d);
    int unsigned sz;
    int unsigned base;
    logic [63:0] mask;
    logic [63:0] v;
    if (f3[1:0] == 2'b11) return d;
    sz   = 1 << f3[1:0];
    base = (off / sz) * sz;
    mask = (64'd1 << (sz * 8)) - 64'd1;
    v    = (d >> (base * 8)) & mask;
    if (!f3[2] && v[sz*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3);
    logic [31:0] i;
    i        = $urandom;
    i[6:0]   = op;
    i[11:7]  = rd;
    i[14:12] = f3;
    return i;
  endfunction

  task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Called at posedge+#1 with instruction/result valid driven; returns at
  // posedge+#1 right after the accepting edge.
  task automatic wait_inst_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!inst_retry_pyro) begin
        ok = 1'b1;
        break;
      end
    end
    check("inst_accept_timeout", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!load_data_retry_pyro) begin
        ok = 1'b1;
        break;
      end
    end
    check("load_accept_timeout", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [63:0] res, input logic [63:0] ld,
                      input logic [63:0] exp_data, input bit has_exp,
                      input int unsigned ld_gap);
    if (has_exp) push_exp(rd, exp_data);
    inst_pyri         = mk_inst(op, rd, f3);
    result_pyri       = res;
    inst_valid_pyri   = 1'b1;
    result_valid_pyri = 1'b1;
    wait_inst_accept();
    inst_valid_pyri   = 1'b0;
    result_valid_pyri = 1'b0;
    if (op == T_LOAD) begin
      repeat (ld_gap) begin
        @(posedge clk);
        #1;
      end
      load_data_pyri       = ld;
      load_data_valid_pyri = 1'b1;
      wait_load_accept();
      load_data_valid_pyri = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !reg_addr_valid_pyro) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Random output backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) begin
      reg_addr_retry_pyri = ($urandom_range(0, 3) == 0);
      reg_data_retry_pyri = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: every output transfer must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset_pyri) begin
      if (reg_addr_valid_pyro || reg_data_valid_pyro)
        check("valid_pair", {63'b0, reg_addr_valid_pyro}, {63'b0, reg_data_valid_pyro});
      if (reg_addr_valid_pyro && reg_data_valid_pyro &&
          !reg_addr_retry_pyri && !reg_data_retry_pyri) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write_out actual rd=%0d data=%h required no write",
                   reg_addr_pyro, reg_data_pyro);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (reg_addr_pyro !== {59'b0, e.rd} || reg_data_pyro !== e.data) begin
            errors++;
            $display("FAIL write_out actual rd=%0d data=%h required rd=%0d data=%h",
                     reg_addr_pyro, reg_data_pyro, e.rd, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [13];
    ops = '{T_ARITH, T_ARITH64, T_ARITHI, T_ARITHI64, T_LUI, T_AUIPC, T_JAL,
            T_JALR, T_LOAD, T_STORE, T_BRANCH, T_SCALL, T_UNKNOWN};

    reset_pyri           = 1'b0;
    inst_pyri            = '0;
    inst_valid_pyri      = 1'b0;
    result_pyri          = '0;
    result_valid_pyri    = 1'b0;
    load_data_pyri       = '0;
    load_data_valid_pyri = 1'b0;
    reg_addr_retry_pyri  = 1'b0;
    reg_data_retry_pyri  = 1'b0;

    // Reset outputs
    #12;
    check("rst_addr_valid", {63'b0, reg_addr_valid_pyro}, 64'd0);
    check("rst_data_valid", {63'b0, reg_data_valid_pyro}, 64'd0);
    check("rst_reg_addr", reg_addr_pyro, 64'd0);
    check("rst_reg_data", reg_data_pyro, 64'd0);
    check("rst_inst_retry", {63'b0, inst_retry_pyro}, 64'd0);
    check("rst_result_retry", {63'b0, result_retry_pyro}, 64'd0);
    check("rst_load_retry", {63'b0, load_data_retry_pyro}, 64'd1);
    @(posedge clk);
    #1;
    reset_pyri = 1'b1;
    @(posedge clk);
    #1;

    // addi rd=5: visible the cycle after acceptance
    reg_addr_retry_pyri = 1'b1;
    reg_data_retry_pyri = 1'b1;
    send(T_ARITHI, 5'd5, 3'd0, 64'h1234, 64'd0, 64'h1234, 1'b1, 0);
    @(negedge clk);
    check("addi_addr_valid", {63'b0, reg_addr_valid_pyro}, 64'd1);
    check("addi_data_valid", {63'b0, reg_data_valid_pyro}, 64'd1);
    check("addi_addr", reg_addr_pyro, 64'd5);
    check("addi_data", reg_data_pyro, 64'h1234);
    @(posedge clk);
    #1;
    reg_addr_retry_pyri = 1'b0;
    reg_data_retry_pyri = 1'b0;
    drain();

    // Store and rd=0 produce no write
    send(T_STORE, 5'd9, 3'd3, 64'h40, 64'd0, 64'd0, 1'b0, 0);
    send(T_ARITH, 5'd0, 3'd0, 64'hFF, 64'd0, 64'd0, 1'b0, 0);
    @(negedge clk);
    check("nowrite_valid", {63'b0, reg_addr_valid_pyro}, 64'd0);
    @(posedge clk);
    #1;

    // LB / LBU at offset 3
    send(T_LOAD, 5'd7, 3'b000, 64'h1003, 64'h0000_0000_8000_0000,
         64'hFFFF_FFFF_FFFF_FF80, 1'b1, 0);
    send(T_LOAD, 5'd7, 3'b100, 64'h1003, 64'h0000_0000_8000_0000,
         64'h0000_0000_0000_0080, 1'b1, 1);
    drain();

    // Backpressure: two entries fill the queue, third is stalled
    reg_addr_retry_pyri = 1'b1;
    send(T_ARITH, 5'd1, 3'd0, 64'h111, 64'd0, 64'h111, 1'b1, 0);
    send(T_ARITH, 5'd2, 3'd0, 64'h222, 64'd0, 64'h222, 1'b1, 0);
    push_exp(5'd3, 64'h333);
    inst_pyri         = mk_inst(T_ARITH, 5'd3, 3'd0);
    result_pyri       = 64'h333;
    inst_valid_pyri   = 1'b1;
    result_valid_pyri = 1'b1;
    @(negedge clk);
    check("full_inst_retry", {63'b0, inst_retry_pyro}, 64'd1);
    check("full_result_retry", {63'b0, result_retry_pyro}, 64'd1);
    @(posedge clk);
    #1;
    reg_addr_retry_pyri = 1'b0;
    wait_inst_accept();
    inst_valid_pyri   = 1'b0;
    result_valid_pyri = 1'b0;
    drain();

    // Load data offered in IDLE is held; LW blocks instructions until data
    load_data_pyri       = 64'h0000_0000_8000_0000;
    load_data_valid_pyri = 1'b1;
    @(negedge clk);
    check("idle_load_retry", {63'b0, load_data_retry_pyro}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_load_retry2", {63'b0, load_data_retry_pyro}, 64'd1);
    check("idle_load_nowrite", {63'b0, reg_addr_valid_pyro}, 64'd0);
    @(posedge clk);
    #1;
    reg_addr_retry_pyri = 1'b1;
    reg_data_retry_pyri = 1'b1;
    push_exp(5'd4, 64'hFFFF_FFFF_8000_0000);
    inst_pyri         = mk_inst(T_LOAD, 5'd4, 3'b010);
    result_pyri       = 64'h2000;
    inst_valid_pyri   = 1'b1;
    result_valid_pyri = 1'b1;
    wait_inst_accept();
    push_exp(5'd8, 64'h88);
    inst_pyri   = mk_inst(T_ARITH, 5'd8, 3'd0);
    result_pyri = 64'h88;
    @(negedge clk);
    check("wait_inst_retry", {63'b0, inst_retry_pyro}, 64'd1);
    check("wait_load_retry", {63'b0, load_data_retry_pyro}, 64'd0);
    @(posedge clk);
    #1;
    load_data_valid_pyri = 1'b0;
    @(negedge clk);
    check("lw_valid", {63'b0, reg_data_valid_pyro}, 64'd1);
    check("lw_addr", reg_addr_pyro, 64'd4);
    check("lw_data", reg_data_pyro, 64'hFFFF_FFFF_8000_0000);
    check("post_load_inst_retry", {63'b0, inst_retry_pyro}, 64'd0);
    @(posedge clk);
    #1;
    inst_valid_pyri     = 1'b0;
    result_valid_pyri   = 1'b0;
    reg_addr_retry_pyri = 1'b0;
    reg_data_retry_pyri = 1'b0;
    drain();

    // Reset during WAIT_LOAD with one queued write
    reg_addr_retry_pyri = 1'b1;
    reg_data_retry_pyri = 1'b1;
    send(T_ARITH, 5'd3, 3'd0, 64'h33, 64'd0, 64'h33, 1'b1, 0);
    inst_pyri         = mk_inst(T_LOAD, 5'd6, 3'b011);
    result_pyri       = 64'h0;
    inst_valid_pyri   = 1'b1;
    result_valid_pyri = 1'b1;
    wait_inst_accept();
    inst_valid_pyri   = 1'b0;
    result_valid_pyri = 1'b0;
    @(negedge clk);
    check("preload_rst_valid", {63'b0, reg_addr_valid_pyro}, 64'd1);
    check("preload_rst_retry", {63'b0, inst_retry_pyro}, 64'd1);
    @(posedge clk);
    #1;
    reset_pyri = 1'b0;
    sb.delete();
    #1;
    check("midrst_addr_valid", {63'b0, reg_addr_valid_pyro}, 64'd0);
    check("midrst_data_valid", {63'b0, reg_data_valid_pyro}, 64'd0);
    check("midrst_data", reg_data_pyro, 64'd0);
    check("midrst_load_retry", {63'b0, load_data_retry_pyro}, 64'd1);
    check("midrst_inst_retry", {63'b0, inst_retry_pyro}, 64'd0);
    @(posedge clk);
    #1;
    reset_pyri          = 1'b1;
    reg_addr_retry_pyri = 1'b0;
    reg_data_retry_pyri = 1'b0;
    @(negedge clk);
    check("postrst_valid", {63'b0, reg_addr_valid_pyro}, 64'd0);
    check("postrst_inst_retry", {63'b0, inst_retry_pyro}, 64'd0);
    check("postrst_load_retry", {63'b0, load_data_retry_pyro}, 64'd1);
    @(posedge clk);
    #1;

    // Randomized traffic under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [63:0] res;
      logic [63:0] ld;
      logic [63:0] exp_d;
      op  = ops[$urandom_range(0, 12)];
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      f3  = 3'($urandom);
      res = {$urandom, $urandom};
      ld  = {$urandom, $urandom};
      // A lone valid on one channel must not be consumed
      if ($urandom_range(0, 3) == 0) begin
        inst_pyri = mk_inst(T_ARITH, 5'd31, 3'd0);
        result_pyri = 64'hDEAD;
        if ($urandom_range(0, 1) == 0) inst_valid_pyri = 1'b1;
        else result_valid_pyri = 1'b1;
        @(posedge clk);
        #1;
        inst_valid_pyri   = 1'b0;
        result_valid_pyri = 1'b0;
      end
      exp_d = (op == T_LOAD) ? ref_load(f3, res[2:0], ld) : res;
      send(op, rd, f3, res, ld, exp_d, writes_rd(op) && (rd != 5'd0),
           $urandom_range(0, 2));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    reg_addr_retry_pyri = 1'b0;
    reg_data_retry_pyri = 1'b0;
    drain();
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_valid", {63'b0, reg_addr_valid_pyro}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pyrm_writeback_block.md
# pyrm_writeback_block

Writeback stage of the pyrm RV64 pipeline: drives the decode stage's register-write channel (`reg_addr`/`reg_data`). Consumes executed instructions with their results plus load data from the data memory, formats loads (byte select, sign/zero extend), and queues register writes in order through a small FIFO. Every write it emits clears the matching in-use bit of decode's scoreboard.

## Interface
- `FIFO_DEPTH`, 2: write-queue entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `reset_pyri`  in  1  asynchronous, active-low reset.
- `inst_pyri`  in  32  executed instruction.
- `inst_valid_pyri` / `inst_retry_pyro`  in / out  1  handshake.
- `result_pyri`  in  64  ALU result, or effective address for loads.
- `result_valid_pyri` / `result_retry_pyro`  in / out  1  handshake.
- `load_data_pyri`  in  64  aligned doubleword from data memory.
- `load_data_valid_pyri` / `load_data_retry_pyro`  in / out  1  handshake.
- `reg_addr_pyro`  out  64  destination register in [4:0]; [63:5] always 0.
- `reg_addr_valid_pyro` / `reg_addr_retry_pyri`  out / in  1  handshake.
- `reg_data_pyro`  out  64  write data.
- `reg_data_valid_pyro` / `reg_data_retry_pyri`  out / in  1  handshake.

## Operation
- A transfer occurs on a channel when valid=1 and retry=0. Retry depends only on registered state.
- `stall` = (count == FIFO_DEPTH) or state == WAIT_LOAD. `inst_retry_pyro` = `result_retry_pyro` = `stall`.
- An instruction is accepted only when both `inst_valid_pyri` and `result_valid_pyri` are 1 and `stall`=0. A lone valid is held and not consumed.
- Fields: op = inst[6:0], rd = inst[11:7], funct3 = inst[14:12].
- These opcodes write rd: OP_ARITH, OP_64ARITH, OP_ARITH_I, OP_64ARITH_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD. OP_STORE, OP_BRANCH, SCALL and unknown opcodes are consumed with no write.
- An instruction with rd = 0 is consumed with no push.
- Non-load write: push {rd, result} on the accept cycle.
- State machine IDLE / WAIT_LOAD:
  - IDLE → WAIT_LOAD on an accepted OP_LOAD, including rd = 0. Latch rd, funct3 and result[2:0] (off).
  - WAIT_LOAD → IDLE on load-data accept.
- `load_data_retry_pyro` = !(state == WAIT_LOAD and count < FIFO_DEPTH). Load data offered in IDLE is held.
- Load extraction from `load_data_pyri`:
  - 000 LB: byte at off, sign-extended.
  - 001 LH: half at {off[2:1],0}, sign-extended.
  - 010 LW: word at {off[2],00}, sign-extended.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: as LB/LH/LW, zero-extended.
  - 111: treated as LD.
  - Push {rd, extracted} on accept unless rd = 0.
- FIFO output:
  - `reg_addr_valid_pyro` = `reg_data_valid_pyro` = !empty.
  - Outputs show the head entry; they are 0 when empty.
  - Pop when both valids are 1 and both retries are 0. A single retry=1 blocks the pop.
- When full, a same-cycle pop does not enable a push. Push is gated on the registered count only.
- Writes leave in acceptance order.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, latched fields 0.
- Outputs while in reset: all `*_valid_pyro` = 0; `reg_addr_pyro` = `reg_data_pyro` = 0; `inst_retry_pyro` = `result_retry_pyro` = 0; `load_data_retry_pyro` = 1.
- Non-load latency: accepted in cycle N → write visible on output in N+1.
- Load latency: data accepted in cycle M → write visible in M+1.
- Throughput: one non-load per cycle; loads occupy at least 2 cycles (instruction cycle + data cycle).
- Reset asserted mid-operation: queued writes and any pending load are discarded.

## Structure
- Opcode macros come from `rv64.vh`. Add load funct3 constants (`F3_LB` … `F3_LWU`) to it.
- Local typedef: `wb_entry_t` = {logic [4:0] rd; logic [63:0] data}.
- Sub-module `pyrm_wb_fifo`:
  - Parameterised synchronous FIFO, DEPTH deep, with count, full and empty.
  - Same clock and reset as the parent.
- Load extraction is a combinational function in the parent.

## Test plan
- Non-load write: addi rd=5, result 0x1234 → next cycle reg_addr=5, reg_data=0x1234, both valids 1; popped with retries 0.
- No-write cases: store rd field=9, then add rd=0, result 0xFF → both consumed, no valid on reg outputs.
- LB and LBU: LB rd=7, addr 0x1003, load_data 0x0000_0000_8000_0000 → 0xFFFF_FFFF_FFFF_FF80. Same with LBU → 0x80.
- Backpressure: hold reg_addr_retry=1 and issue adds rd=1,2,3.
  - rd=1 and rd=2 are accepted; `inst_retry_pyro`=1 for rd=3.
  - Release retry → writes 1, 2, 3 in order.
- Load ordering: load data offered in IDLE → `load_data_retry_pyro`=1, no write. LW rd=4 accepted → `inst_retry_pyro`=1 until data 0x8000_0000 arrives → write 0xFFFF_FFFF_8000_0000.
- Reset mid-load: assert reset during WAIT_LOAD with 1 queued entry → valids 0 immediately; after release, state IDLE and FIFO empty.
